// File: rtl/traffic_ctrl_param.sv
// Parametrised round-robin traffic-light controller with latched pedestrian WALK phases
// and an all-red emergency override. Lamp outputs are registered decodes of the next state.
module traffic_ctrl_param #(
  parameter int unsigned NUM_DIR    = 2,
  parameter int unsigned GREEN_CYC  = 8,
  parameter int unsigned YELLOW_CYC = 3,
  parameter int unsigned CLR_CYC    = 2,
  parameter int unsigned WALK_CYC   = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EMERG,
  input  logic [NUM_DIR-1:0] PED_REQ,
  output logic [NUM_DIR-1:0] GREEN,
  output logic [NUM_DIR-1:0] YELLOW,
  output logic [NUM_DIR-1:0] RED,
  output logic [NUM_DIR-1:0] WALK,
  output logic [NUM_DIR-1:0] PED_PEND,
  output logic [2:0]         STATE
);

  localparam int unsigned DIR_W   = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;
  localparam int unsigned MAX_GY  = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
  localparam int unsigned MAX_CW  = (CLR_CYC > WALK_CYC) ? CLR_CYC : WALK_CYC;
  localparam int unsigned MAX_CYC = (MAX_GY > MAX_CW) ? MAX_GY : MAX_CW;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [DIR_W-1:0] LAST_DIR    = DIR_W'(NUM_DIR - 1);
  localparam logic [TMR_W-1:0] GREEN_LAST  = TMR_W'(GREEN_CYC - 1);
  localparam logic [TMR_W-1:0] YELLOW_LAST = TMR_W'(YELLOW_CYC - 1);
  localparam logic [TMR_W-1:0] CLR_LAST    = TMR_W'(CLR_CYC - 1);
  localparam logic [TMR_W-1:0] WALK_LAST   = TMR_W'(WALK_CYC - 1);

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_WALK   = 3'd3,
    S_EMERG  = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [DIR_W-1:0]   r_dir, w_dir_nxt;
  logic [TMR_W-1:0]   r_timer, w_timer_nxt;
  logic [NUM_DIR-1:0] r_pend, w_pend_nxt;
  logic [NUM_DIR-1:0] r_served, w_served_nxt;
  logic               w_expire;
  logic [NUM_DIR-1:0] w_dir_oh;
  logic [NUM_DIR-1:0] w_green_nxt, w_yellow_nxt, w_red_nxt, w_walk_nxt;

  // State and lamp registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_CLEAR;
      r_dir    <= '0;
      r_timer  <= '0;
      r_pend   <= '0;
      r_served <= '0;
      GREEN    <= '0;
      YELLOW   <= '0;
      RED      <= '1;
      WALK     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_dir    <= w_dir_nxt;
      r_timer  <= w_timer_nxt;
      r_pend   <= w_pend_nxt;
      r_served <= w_served_nxt;
      GREEN    <= w_green_nxt;
      YELLOW   <= w_yellow_nxt;
      RED      <= w_red_nxt;
      WALK     <= w_walk_nxt;
    end
  end

  // Next-state, timer, direction and pedestrian bookkeeping
  always_comb begin
    w_state_nxt = r_state;
    w_expire    = 1'b0;
    case (r_state)
      S_CLEAR:  w_expire = (r_timer == CLR_LAST);
      S_GREEN:  w_expire = (r_timer == GREEN_LAST);
      S_YELLOW: w_expire = (r_timer == YELLOW_LAST);
      S_WALK:   w_expire = (r_timer == WALK_LAST);
      default:  w_expire = 1'b0;
    endcase

    if (EMERG) begin
      w_state_nxt = S_EMERG;
    end else begin
      case (r_state)
        S_CLEAR:  if (w_expire) w_state_nxt = (r_pend != '0) ? S_WALK : S_GREEN;
        S_GREEN:  if (w_expire) w_state_nxt = S_YELLOW;
        S_YELLOW: if (w_expire) w_state_nxt = S_CLEAR;
        S_WALK:   if (w_expire) w_state_nxt = S_GREEN;
        default:  w_state_nxt = S_CLEAR;
      endcase
    end

    w_timer_nxt = (w_state_nxt != r_state) ? '0 : r_timer + TMR_W'(1);

    w_dir_nxt = r_dir;
    if (r_state == S_YELLOW && w_state_nxt == S_CLEAR)
      w_dir_nxt = (r_dir == LAST_DIR) ? '0 : r_dir + DIR_W'(1);

    // An interrupted WALK forgets what it served so those requests stay pending
    w_served_nxt = r_served;
    if (w_state_nxt == S_EMERG)
      w_served_nxt = '0;
    else if (w_state_nxt == S_WALK && r_state != S_WALK)
      w_served_nxt = r_pend;

    w_pend_nxt = r_pend | PED_REQ;
    if (r_state == S_WALK && w_state_nxt == S_GREEN)
      w_pend_nxt = (r_pend & ~r_served) | PED_REQ;
  end

  // Lamp decode of the upcoming state, so registered lamps always match the current state
  always_comb begin
    w_dir_oh     = NUM_DIR'(1) << w_dir_nxt;
    w_green_nxt  = '0;
    w_yellow_nxt = '0;
    w_red_nxt    = '1;
    w_walk_nxt   = '0;
    case (w_state_nxt)
      S_GREEN: begin
        w_green_nxt = w_dir_oh;
        w_red_nxt   = ~w_dir_oh;
      end
      S_YELLOW: begin
        w_yellow_nxt = w_dir_oh;
        w_red_nxt    = ~w_dir_oh;
      end
      S_WALK:  w_walk_nxt = w_served_nxt;
      default: w_red_nxt  = '1;
    endcase
  end

  assign PED_PEND = r_pend;
  assign STATE    = r_state;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param: default 2-approach instance plus a
// 3-approach, 1-cycle-green instance, checked cycle by cycle against hand-derived phases.
module tb_traffic_ctrl_param;

  logic       clk;
  logic       rst;
  logic       emerg;
  logic [1:0] ped_req;
  logic [1:0] green, yellow, red, walk, ped_pend;
  logic [2:0] state;

  logic [2:0] ped_req3;
  logic [2:0] green3, yellow3, red3, walk3, ped_pend3;
  logic [2:0] state3;

  int n_assert = 0;
  int n_fail   = 0;

  traffic_ctrl_param u_dut (
    .CLK(clk), .RST(rst), .EMERG(emerg), .PED_REQ(ped_req),
    .GREEN(green), .YELLOW(yellow), .RED(red), .WALK(walk),
    .PED_PEND(ped_pend), .STATE(state)
  );

  traffic_ctrl_param #(.NUM_DIR(3), .GREEN_CYC(1)) u_dut3 (
    .CLK(clk), .RST(rst), .EMERG(emerg), .PED_REQ(ped_req3),
    .GREEN(green3), .YELLOW(yellow3), .RED(red3), .WALK(walk3),
    .PED_PEND(ped_pend3), .STATE(state3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {green, yellow, red, walk} for the 2-approach instance
  function automatic logic [7:0] lamps2(input int st, input int d, input logic [1:0] w);
    logic [1:0] oh;
    oh = (d == 0) ? 2'b01 : 2'b10;
    case (st)
      1:       lamps2 = {oh, 2'b00, ~oh, 2'b00};
      2:       lamps2 = {2'b00, oh, ~oh, 2'b00};
      3:       lamps2 = {4'b0000, 2'b11, w};
      default: lamps2 = {4'b0000, 2'b11, 2'b00};
    endcase
  endfunction

  task automatic expect2(input string tag, input int st, input int d,
                         input logic [1:0] w, input logic [1:0] pend);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_lamps"}, 32'({green, yellow, red, walk}), 32'(lamps2(st, d, w)));
    check({tag, "_pend"}, 32'(ped_pend), 32'(pend));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    emerg = 1'b0;
    ped_req = 2'b00;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int st, d, p;
    logic [2:0] oh3;
    logic [14:0] exp3;

    rst = 1'b1;
    emerg = 1'b0;
    ped_req = 2'b00;
    ped_req3 = 3'b000;
    step();
    step();
    // Reset state while reset held
    expect2("rst", 0, 0, 2'b00, 2'b00);
    check("rst3", 32'({state3, green3, yellow3, red3, walk3, ped_pend3}),
          32'({3'd0, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000}));
    rst = 1'b0;

    // Free-running sequence, both instances, two full periods of the default one
    for (int k = 0; k < 54; k++) begin
      if (k > 0) step();
      p = k % 26;
      if (p < 2)       begin st = 0; d = 0; end
      else if (p < 10) begin st = 1; d = 0; end
      else if (p < 13) begin st = 2; d = 0; end
      else if (p < 15) begin st = 0; d = 0; end
      else if (p < 23) begin st = 1; d = 1; end
      else             begin st = 2; d = 1; end
      expect2($sformatf("t1_k%0d", k), st, d, 2'b00, 2'b00);

      if (k <= 20) begin
        p = k % 6;
        oh3 = 3'b001 << ((k / 6) % 3);
        if (p < 2)       exp3 = {3'd0, 3'b000, 3'b000, 3'b111, 3'b000};
        else if (p == 2) exp3 = {3'd1, oh3, 3'b000, ~oh3, 3'b000};
        else             exp3 = {3'd2, 3'b000, oh3, ~oh3, 3'b000};
        check($sformatf("t6_k%0d", k),
              32'({state3, green3, yellow3, red3, walk3, ped_pend3}), 32'({exp3, 3'b000}));
      end
    end

    // Pedestrian request in GREEN dir 0 inserts WALK before GREEN dir 1
    do_reset();
    advance(2);
    expect2("t2_k2", 1, 0, 2'b00, 2'b00);
    ped_req = 2'b10;
    step();
    ped_req = 2'b00;
    expect2("t2_k3", 1, 0, 2'b00, 2'b10);
    for (int k = 4; k <= 20; k++) begin
      step();
      if (k < 10)      expect2($sformatf("t2_k%0d", k), 1, 0, 2'b00, 2'b10);
      else if (k < 13) expect2($sformatf("t2_k%0d", k), 2, 0, 2'b00, 2'b10);
      else if (k < 15) expect2($sformatf("t2_k%0d", k), 0, 0, 2'b00, 2'b10);
      else if (k < 20) expect2($sformatf("t2_k%0d", k), 3, 0, 2'b10, 2'b10);
      else             expect2($sformatf("t2_k%0d", k), 1, 1, 2'b00, 2'b00);
    end

    // Emergency for 4 cycles during GREEN dir 1 restarts that green in full
    do_reset();
    advance(17);
    expect2("t3_k17", 1, 1, 2'b00, 2'b00);
    emerg = 1'b1;
    for (int k = 18; k <= 21; k++) begin
      step();
      expect2($sformatf("t3_k%0d", k), 4, 0, 2'b00, 2'b00);
    end
    emerg = 1'b0;
    for (int k = 22; k <= 32; k++) begin
      step();
      if (k < 24)      expect2($sformatf("t3_k%0d", k), 0, 1, 2'b00, 2'b00);
      else if (k < 32) expect2($sformatf("t3_k%0d", k), 1, 1, 2'b00, 2'b00);
      else             expect2($sformatf("t3_k%0d", k), 2, 1, 2'b00, 2'b00);
    end

    // Emergency cutting a WALK short: request stays pending and is re-served
    do_reset();
    advance(2);
    ped_req = 2'b10;
    step();
    ped_req = 2'b00;
    advance(13);
    expect2("t7_k16", 3, 0, 2'b10, 2'b10);
    emerg = 1'b1;
    step();
    expect2("t7_k17", 4, 0, 2'b00, 2'b10);
    emerg = 1'b0;
    for (int k = 18; k <= 25; k++) begin
      step();
      if (k < 20)      expect2($sformatf("t7_k%0d", k), 0, 1, 2'b00, 2'b10);
      else if (k < 25) expect2($sformatf("t7_k%0d", k), 3, 1, 2'b10, 2'b10);
      else             expect2($sformatf("t7_k%0d", k), 1, 1, 2'b00, 2'b00);
    end

    // Request on the last WALK cycle survives the clear and is served next time
    do_reset();
    advance(2);
    ped_req = 2'b01;
    step();
    ped_req = 2'b00;
    advance(16);
    expect2("t5_k19", 3, 0, 2'b01, 2'b01);
    ped_req = 2'b01;
    step();
    ped_req = 2'b00;
    expect2("t5_k20", 1, 1, 2'b00, 2'b01);
    advance(13);
    expect2("t5_k33", 3, 0, 2'b01, 2'b01);
    advance(4);
    expect2("t5_k37", 3, 0, 2'b01, 2'b01);
    step();
    expect2("t5_k38", 1, 0, 2'b00, 2'b00);

    // Asynchronous reset between edges mid-YELLOW
    do_reset();
    advance(10);
    ped_req = 2'b01;
    step();
    ped_req = 2'b00;
    expect2("t4_k11", 2, 0, 2'b00, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    expect2("t4_async", 0, 0, 2'b00, 2'b00);
    #2;
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k < 2)       expect2($sformatf("t4_r%0d", k), 0, 0, 2'b00, 2'b00);
      else if (k < 10) expect2($sformatf("t4_r%0d", k), 1, 0, 2'b00, 2'b00);
      else             expect2($sformatf("t4_r%0d", k), 2, 0, 2'b00, 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
